// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// - instr_name_e    : operation names carried on the station feed bus (UNKNOWN = empty slot)
// - muldiv_state_e  : control FSM states
// - MuldivOps       : the M-extension subset of instr_name_e
// - is_muldiv/is_mul_op/is_div_op : operation classification helpers
package muldiv_unit_pkg;

    localparam int unsigned MuldivXlen = 32;

    typedef enum logic [5:0] {
        UNKNOWN,
        LUI,
        AUIPC,
        ADD,
        SUB,
        SLL,
        SLT,
        LW,
        SW,
        BEQ,
        JAL,
        MUL,
        MULH,
        MULHSU,
        MULHU,
        DIV,
        DIVU,
        REM,
        REMU
    } instr_name_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_e;

    localparam int unsigned NumMuldivOps = 8;

    localparam instr_name_e MuldivOps [NumMuldivOps] = '{
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    };

    function automatic logic is_muldiv(instr_name_e name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NumMuldivOps; i++) begin
            if (name == MuldivOps[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic is_mul_op(instr_name_e name);
        return name inside {MUL, MULH, MULHSU, MULHU};
    endfunction

    function automatic logic is_div_op(instr_name_e name);
        return name inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative arithmetic core: shift-add multiplier and restoring divider sharing one
// accumulator pair, plus final sign correction and result selection.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            load operand magnitudes and sign/bypass flags from op_i/rs1_i/rs2_i
//   step_i             perform one iteration
//   finish_i           asserted with the last step_i; result_o is valid only then
//   op_i, rs1_i, rs2_i operation and raw operands, held stable by the caller
//   result_o           corrected result (zero when finish_i is low)
module muldiv_datapath
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = MuldivXlen
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            finish_i,
    input  instr_name_e     op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    // hi: product high half / partial remainder; lo: multiplier / dividend-quotient.
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic            q_neg_q, q_neg_d; // product / quotient sign
    logic            r_neg_q, r_neg_d; // remainder sign
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;

    logic            a_signed, b_signed, a_neg, b_neg, div_op;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   sum, shifted, diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    always_comb begin
        div_op   = is_div_op(op_i);
        // MUL low half is sign-agnostic, so it runs as an unsigned product.
        a_signed = op_i inside {MULH, MULHSU, DIV, REM};
        b_signed = op_i inside {MULH, DIV, REM};
        a_neg    = a_signed & rs1_i[XLEN-1];
        b_neg    = b_signed & rs2_i[XLEN-1];
        a_mag    = a_neg ? (~rs1_i + 1'b1) : rs1_i;
        b_mag    = b_neg ? (~rs2_i + 1'b1) : rs2_i;

        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;

        sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, opnd_q};

        if (start_i) begin
            hi_d    = '0;
            lo_d    = div_op ? a_mag : b_mag;
            opnd_d  = div_op ? b_mag : a_mag;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            div0_d  = (rs2_i == '0);
            ovf_d   = (op_i inside {DIV, REM}) && (rs1_i == MinNeg) && (rs2_i == '1);
        end else if (step_i) begin
            if (div_op) begin
                if (!diff[XLEN]) begin
                    hi_d = diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = shifted[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[XLEN:1];
                lo_d = {sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    // Result is formed from the post-step values so the last step and selection share a cycle.
    always_comb begin
        prod     = {hi_d, lo_d};
        prod_fix = q_neg_q ? (~prod + 1'b1) : prod;
        quo_fix  = q_neg_q ? (~lo_d + 1'b1) : lo_d;
        rem_fix  = r_neg_q ? (~hi_d + 1'b1) : hi_d;
        result_o = '0;
        if (finish_i) begin
            case (op_i)
                MUL:                  result_o = prod_fix[XLEN-1:0];
                MULH, MULHSU, MULHU:  result_o = prod_fix[2*XLEN-1:XLEN];
                DIV, DIVU: begin
                    if (div0_q)     result_o = '1;
                    else if (ovf_q) result_o = MinNeg;
                    else            result_o = quo_fix;
                end
                REM, REMU: begin
                    if (div0_q)     result_o = rs1_i;
                    else if (ovf_q) result_o = '0;
                    else            result_o = rem_fix;
                end
                default:              result_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execution unit fed by a reservation station and broadcasting on the CDB.
// Accepts one M op, pops it with a one-cycle `next`, iterates for ITERATIONS cycles
// (after one setup cycle), then requests the CDB and holds the result until granted.
// Tagged work is dropped on delete_tag.
// Ports:
//   clock, reset (async active-low)
//   feed_*       offered instruction from the station
//   delete_tag   speculative flush
//   next, busy   pop strobe and occupancy
//   cdb_request/cdb_grant, cdb_result/cdb_rrn/cdb_arn  broadcast handshake and payload
// Optional: define MULDIV_SINGLE_CYCLE_MUL_EN to compute MUL* with a combinational
// multiplier at the accept edge and go straight to DONE.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN       = MuldivXlen,
    parameter int unsigned ITERATIONS = XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  instr_name_e     feed_instr_name,
    input  logic [XLEN-1:0] feed_data_1,
    input  logic [XLEN-1:0] feed_data_2,
    input  logic [5:0]      feed_rrn,
    input  logic [5:0]      feed_arn,
    input  logic            feed_tag,
    input  logic            delete_tag,
    output logic            next,
    output logic            busy,
    output logic            cdb_request,
    input  logic            cdb_grant,
    output logic [XLEN-1:0] cdb_result,
    output logic [5:0]      cdb_rrn,
    output logic [5:0]      cdb_arn
);

    localparam int unsigned CntW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(ITERATIONS - 1);

    muldiv_state_e   state_q, state_d;
    logic [CntW-1:0] counter_q, counter_d;
    logic            setup_q, setup_d;   // first CALC cycle: load magnitudes
    logic            next_q;
    logic            tag_q, tag_d;
    instr_name_e     op_q, op_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [5:0]      rrn_q, rrn_d, arn_q, arn_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept, flush;
    logic            dp_start, dp_step, dp_finish;
    logic [XLEN-1:0] dp_result;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    logic [2*XLEN-1:0] sc_a, sc_b, sc_prod;
    logic [XLEN-1:0]   sc_result;

    always_comb begin
        sc_a = (feed_instr_name inside {MULH, MULHSU}) ?
               {{XLEN{feed_data_1[XLEN-1]}}, feed_data_1} : {{XLEN{1'b0}}, feed_data_1};
        sc_b = (feed_instr_name == MULH) ?
               {{XLEN{feed_data_2[XLEN-1]}}, feed_data_2} : {{XLEN{1'b0}}, feed_data_2};
        // Extended operands make the truncated product correct for every signedness.
        sc_prod   = sc_a * sc_b;
        sc_result = (feed_instr_name == MUL) ? sc_prod[XLEN-1:0] : sc_prod[2*XLEN-1:XLEN];
    end
`endif

    assign flush = delete_tag && tag_q;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        setup_d   = setup_q;
        tag_d     = tag_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rrn_d     = rrn_q;
        arn_d     = arn_q;
        result_d  = result_q;
        accept    = 1'b0;
        dp_start  = 1'b0;
        dp_step   = 1'b0;
        dp_finish = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (is_muldiv(feed_instr_name) && !(delete_tag && feed_tag)) begin
                    accept    = 1'b1;
                    op_d      = feed_instr_name;
                    rs1_d     = feed_data_1;
                    rs2_d     = feed_data_2;
                    rrn_d     = feed_rrn;
                    arn_d     = feed_arn;
                    tag_d     = feed_tag;
                    counter_d = '0;
                    setup_d   = 1'b1;
                    state_d   = CALC;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
                    if (is_mul_op(feed_instr_name)) begin
                        setup_d  = 1'b0;
                        result_d = sc_result;
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_d   = IDLE;
                    setup_d   = 1'b0;
                    counter_d = '0;
                end else if (setup_q) begin
                    dp_start = 1'b1;
                    setup_d  = 1'b0;
                end else begin
                    dp_step = 1'b1;
                    if (counter_q == LastCnt) begin
                        dp_finish = 1'b1;
                        result_d  = dp_result;
                        counter_d = '0;
                        state_d   = DONE;
                    end else begin
                        counter_d = counter_q + CntW'(1);
                    end
                end
            end
            DONE: begin
                // Flush takes priority; a coincident grant is simply left unused.
                if (flush || cdb_grant) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            setup_q   <= 1'b0;
            next_q    <= 1'b0;
            tag_q     <= 1'b0;
            op_q      <= UNKNOWN;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rrn_q     <= '0;
            arn_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            setup_q   <= setup_d;
            next_q    <= accept;
            tag_q     <= tag_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rrn_q     <= rrn_d;
            arn_q     <= arn_d;
            result_q  <= result_d;
        end
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk_i    (clock),
        .rst_ni   (reset),
        .start_i  (dp_start),
        .step_i   (dp_step),
        .finish_i (dp_finish),
        .op_i     (op_q),
        .rs1_i    (rs1_q),
        .rs2_i    (rs2_q),
        .result_o (dp_result)
    );

    assign next        = next_q;
    assign busy        = (state_q != IDLE);
    assign cdb_request = (state_q == DONE);
    assign cdb_result  = result_q;
    assign cdb_rrn     = rrn_q;
    assign cdb_arn     = arn_q;

endmodule
